// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit holding the architectural HI/LO registers.
// Ports: clk; rst_n (asynchronous, active-low); md_op (E-stage op code);
//   A/B (forwarded rs/rt operands); cancel (only with MDU_CANCEL_EN: flushes
//   the E-stage op); start (comb, mult/div launch); busy (registered, op in
//   flight); HI/LO (architectural registers); md_out (mfhi/mflo read data).
// Optional feature macro: MDU_CANCEL_EN adds the cancel input.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] MULT_LD  = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LD   = 4'(DIV_CYCLES - 1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;
  logic        kill, done, md_go;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    md_go   = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    done    = (state_q == RUN) && (cnt_q == 4'd0);
    state_d = start ? RUN : done ? IDLE : state_q;
  end
  always_comb begin
    busy   = state_q == RUN;
    start  = md_go && (state_q == IDLE) && !kill;
    md_out = (md_op == OP_MFHI) ? hi_q : (md_op == OP_MFLO) ? lo_q : 32'd0;
  end
  // Sign-extending to 64 bits lets one unsigned multiplier give the signed product.
  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    a_neg  = (md_op == OP_DIV) && A[31];
    b_neg  = (md_op == OP_DIV) && B[31];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end
  // A divide by zero stages the current HI/LO, so the commit leaves them unchanged.
  always_comb begin
    cnt_d = start ? ((md_op <= OP_MULTU) ? MULT_LD : DIV_LD)
          : (busy && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    {hi_nxt_d, lo_nxt_d} = !start ? {hi_nxt_q, lo_nxt_q}
                         : (md_op == OP_MULT) ? prod_s
                         : (md_op == OP_MULTU) ? prod_u
                         : (B == 32'd0) ? {hi_q, lo_q} : {rem, quo};
    hi_d = done ? hi_nxt_q : (!busy && !kill && md_op == OP_MTHI) ? A : hi_q;
    lo_d = done ? lo_nxt_q : (!busy && !kill && md_op == OP_MTLO) ? A : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_nxt_q <= 32'd0;
      lo_nxt_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_nxt_q <= hi_nxt_d;
      lo_nxt_q <= lo_nxt_d;
    end
  end
  assign HI = hi_q;
  assign LO = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed check of mdu against a behavioural HI/LO model.
module tb_mdu;
  logic        clk = 1'b0, rst_n = 1'b0, cancel = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        start, busy;
  logic [31:0] HI, LO, md_out;
  int n_vec = 0, n_err = 0, busy_cnt = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int m_left = 0;

  mdu dut (
    .clk(clk), .rst_n(rst_n), .md_op(md_op), .A(A), .B(B),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .start(start), .busy(busy), .HI(HI), .LO(LO), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check();
    logic es;
    es = rst_n && m_left == 0 && !cancel && md_op >= 4'd1 && md_op <= 4'd4;
    chk("start", {31'd0, start}, {31'd0, es});
    chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("md_out", md_out, md_op == 4'd5 ? m_hi : md_op == 4'd6 ? m_lo : 32'd0);
    if (busy && md_op >= 4'd1 && md_op <= 4'd8) begin
      n_err++;
      $display("FAIL op_in_run md_op=%0d presented while busy", md_op);
    end
  endtask

  // Spec-level model: the result is computed at issue, committed N cycles later.
  task automatic model_edge();
    logic [3:0] op;
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    op = md_op;
    sa = longint'($signed(A));
    sb = longint'($signed(B));
    ua = {32'd0, A};
    ub = {32'd0, B};
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (!cancel) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        m_left = (op <= 4'd2) ? 5 : 10;
        p_hi = m_hi;
        p_lo = m_lo;
        if (op == 4'd1) begin sp = sa * sb; {p_hi, p_lo} = sp; end
        else if (op == 4'd2) begin up = ua * ub; {p_hi, p_lo} = up; end
        else if (B != 32'd0) begin
          if (op == 4'd3) begin sp = sa / sb; p_lo = sp[31:0]; sp = sa % sb; p_hi = sp[31:0]; end
          else begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
        end
      end else if (op == 4'd7) m_hi = A;
      else if (op == 4'd8) m_lo = A;
    end
  endtask

  task automatic op1(input logic [3:0] op, input logic [31:0] a = 0, input logic [31:0] b = 0);
    @(negedge clk);
    md_op = op; A = a; B = b;
    #1;
    check();
    if (busy) busy_cnt++;
    @(posedge clk);
    if (rst_n) model_edge();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    rst_n = 1'b1;
    busy_cnt = 0;
    op1(4'd1, 32'hFFFFFFFE, 32'd3);
    repeat (6) op1(4'd0);
    #2;
    chk("mult_busy_cycles", busy_cnt, 32'd5);
    chk("mult_HI", HI, 32'hFFFFFFFF);
    chk("mult_LO", LO, 32'hFFFFFFFA);
    op1(4'd2, 32'hFFFFFFFE, 32'd3);
    repeat (6) op1(4'd0);
    #2;
    chk("multu_HI", HI, 32'h00000002);
    chk("multu_LO", LO, 32'hFFFFFFFA);
    busy_cnt = 0;
    op1(4'd3, 32'hFFFFFFF9, 32'd2);
    repeat (11) op1(4'd0);
    #2;
    chk("div_busy_cycles", busy_cnt, 32'd10);
    chk("div_LO", LO, 32'hFFFFFFFD);
    chk("div_HI", HI, 32'hFFFFFFFF);
    op1(4'd4, 32'd7, 32'd2);
    repeat (11) op1(4'd0);
    #2;
    chk("divu_LO", LO, 32'd3);
    chk("divu_HI", HI, 32'd1);
    op1(4'd3, 32'h80000000, 32'hFFFFFFFF);
    repeat (11) op1(4'd0);
    #2;
    chk("divovf_LO", LO, 32'h80000000);
    chk("divovf_HI", HI, 32'd0);
    op1(4'd7, 32'h11);
    op1(4'd8, 32'h22);
    busy_cnt = 0;
    op1(4'd3, 32'd5, 32'd0);
    repeat (11) op1(4'd0);
    op1(4'd5);
    #2;
    chk("div0_busy_cycles", busy_cnt, 32'd10);
    chk("div0_HI", HI, 32'h11);
    chk("div0_LO", LO, 32'h22);
    chk("div0_mfhi", md_out, 32'h11);
    op1(4'd1, 32'd3, 32'd4);
    repeat (5) op1(4'd0);
    op1(4'd1, 32'd5, 32'd6);
    repeat (4) op1(4'd0);
    #2;
    chk("b2b_first_LO", LO, 32'd12);
    chk("b2b_busy_t11", {31'd0, busy}, 32'd1);
    op1(4'd0);
    #2;
    chk("b2b_second_LO", LO, 32'd30);
    chk("b2b_idle_t12", {31'd0, busy}, 32'd0);
    op1(4'd7, 32'h55);
    op1(4'd1, 32'hFFFFFFFE, 32'd3);
    op1(4'd0);
    op1(4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; m_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) op1(4'd0);
    #2;
    chk("midrst_nocommit_HI", HI, 32'd0);
    chk("midrst_nocommit_LO", LO, 32'd0);
`ifdef MDU_CANCEL_EN
    cancel = 1'b1;
    op1(4'd3, 32'd7, 32'd2);
    cancel = 1'b0;
    #2;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
`endif
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = (m_left > 0) ? (($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15)))
                        : 4'($urandom_range(0, 15));
`ifdef MDU_CANCEL_EN
      cancel = ($urandom_range(0, 7) == 0);
`endif
      op1(op, rnd_val(), rnd_val());
    end
    cancel = 1'b0;
    repeat (12) op1(4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

E-stage multiply/divide unit for the five-stage MIPS pipeline. It executes mult/multu/div/divu over a fixed multi-cycle latency, and it holds the architectural HI/LO registers. It exposes `start` and `busy` directly upstream of the stall unit, which stalls any D-stage HI/LO-touching instruction while either signal is high. mfhi/mflo read data goes to the E-stage result mux.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `md_op` in 4: E-stage operation.
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO.
  - 9–15 behave as NONE.
- `A` in 32: rs operand, already forwarded.
- `B` in 32: rt operand, already forwarded.
- `cancel` in 1: present only with `MDU_CANCEL_EN` (see Configuration).
- `start` out 1: combinational; high when `md_op` ∈ {1..4} and state is IDLE (and, with the macro, `cancel`=0).
- `busy` out 1: registered; high while an operation is in flight.
- `HI` out 32: registered HI register.
- `LO` out 32: registered LO register.
- `md_out` out 32: combinational read data.
  - `HI` for MFHI, `LO` for MFLO.
  - 0 for all other ops.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1. A 4-bit down-counter `cnt` and 64-bit staging registers `hi_nxt`/`lo_nxt` are live.
- IDLE→RUN on a clock edge with `start`=1:
  - Compute the result from `A`/`B` at that edge and latch it into the staging registers.
  - Load `cnt` with `MULT_CYCLES-1` (ops 1,2) or `DIV_CYCLES-1` (ops 3,4).
- RUN: `cnt` decrements each cycle. On the edge where `cnt`==0, `HI`/`LO` take the staged values and the state returns to IDLE.
- Arithmetic:
  - MULT: `{HI,LO}` = signed 32×32→64.
  - MULTU: `{HI,LO}` = unsigned 32×32→64.
  - DIV: `LO`=quotient, `HI`=remainder, signed, truncating toward zero. The remainder takes the sign of the dividend.
  - DIVU: same as DIV but unsigned.
  - DIV of 0x80000000 by 0xFFFFFFFF gives `LO`=0x80000000, `HI`=0.
- Divide by zero (`B`==0):
  - The full busy period still runs.
  - `HI`/`LO` are left unchanged at completion.
- MTHI/MTLO in IDLE: write `A` to `HI`/`LO` at the edge.
- Ops while RUN:
  - Any op 1–8 presented while RUN is ignored; `HI`/`LO`/`cnt` are unaffected.
  - The stall unit guarantees this never happens. The bench flags it as an assertion failure.
- Reset (asynchronous, any time, including mid-operation):
  - State=IDLE, `busy`=0, `cnt`=0, `HI`=0, `LO`=0, staging registers=0.
  - An in-flight result is discarded.

## Timing
- `start` is asserted in cycle t:
  - `busy`=1 in cycles t+1 … t+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - `HI`/`LO` show the new values from cycle t+N+1, when `busy` returns to 0.
- A second mult/div may start in cycle t+N+1; no idle gap is needed.
- MTHI/MTLO in cycle t: new value visible from cycle t+1.
- MFHI/MFLO: `md_out` reflects the current `HI`/`LO` in the same cycle (zero latency).
- `start` and `busy` are never both 1.

## Configuration
- Macro `MDU_CANCEL_EN`, defined: adds the `cancel` input (the E-stage instruction is being flushed by an exception).
  - `cancel`=1 in a cycle suppresses `start` and any MTHI/MTLO write in that cycle.
  - `cancel` during RUN has no effect; the operation completes and commits.
- Macro not defined:
  - The port is absent.
  - Every op 1–8 presented in IDLE takes effect unconditionally.

## Test plan
- MULT, `A`=0xFFFFFFFE (−2), `B`=3 → `busy` high exactly 5 cycles; then `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFA.
- MULTU, same operands → `HI`=0x00000002, `LO`=0xFFFFFFFA.
- DIV, `A`=−7, `B`=2 → `busy` 10 cycles; then `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF.
- DIVU, `A`=7, `B`=2 → `LO`=3, `HI`=1.
- DIV, `B`=0:
  - Precede it with MTHI `A`=0x11 and MTLO `A`=0x22.
  - Required: `busy` lasts 10 cycles, `HI`=0x11 and `LO`=0x22 are retained, and MFHI `md_out`=0x11.
- Reset and back-to-back:
  - Start a MULT, then drop `rst_n` at busy cycle 3 → `busy`=0 and `HI`=`LO`=0 immediately, with no later commit.
  - Issue two back-to-back MULTs (second at cycle t+6) → second result commits at t+12.
  - With `MDU_CANCEL_EN` defined: `cancel`=1 alongside DIV → `start`=0 and `busy` stays 0.
